// File: rtl/fft_iter_core.sv
// Iterative in-place radix-2 DIF FFT/IFFT over a serially loaded frame buffer.
// Loads N samples, runs one butterfly per cycle, then streams the natural-order spectrum.
`timescale 1ns/1ps
module fft_iter_core #(
  parameter int  N      = 16,
  parameter int  DW     = 16,
  parameter int  IW     = 32,
  parameter int  LANES  = 16,
  parameter int  FRAMES = 64,
  localparam int LOGN   = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fir_valid,
  input  logic [DW-1:0]         fir_d,
  input  logic                  inverse,
  output logic                  in_ready,
  output logic [LOGN-2:0]       tw_addr,
  input  logic [IW-1:0]         tw_re,
  input  logic [IW-1:0]         tw_im,
  output logic                  fftr_valid,
  output logic                  ffti_valid,
  output logic [LANES*DW-1:0]   fft_d,
  output logic                  frame_done,
  output logic                  done,
  output logic                  ovf,
  output logic                  sat
);

  localparam int BEATS = N / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FW    = $clog2(FRAMES + 1);
  localparam int SW    = $clog2(LOGN) + 1;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUT_R, OUT_I} state_t;

  state_t                state, state_n;
  logic [LOGN-1:0]       smp_cnt;
  logic [LOGN-2:0]       bf_cnt;
  logic [SW-1:0]         stage;
  logic [BW-1:0]         beat;
  logic [FW-1:0]         frame_cnt;
  logic                  inv_q, frame_done_q, done_q, ovf_q, sat_q;
  logic                  last_beat, lane_sat;

  logic signed [IW-1:0]  mem_re [N];
  logic signed [IW-1:0]  mem_im [N];

  logic [LOGN-1:0]       b_ext, h, j, top, bot;
  logic signed [IW-1:0]  xt_re, xt_im, xb_re, xb_im, d_re, d_im, w_re, w_im, y_re, y_im;
  logic signed [2*IW-1:0] p_rr, p_ii, p_ri, p_ir, s_re, s_im;
  logic [LOGN-1:0]       out_addr;
  logic signed [IW-1:0]  v_raw, v;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
    return r;
  endfunction

  assign in_ready   = (state == LOAD);
  assign fftr_valid = (state == OUT_R);
  assign ffti_valid = (state == OUT_I);
  assign frame_done = frame_done_q;
  assign done       = done_q;
  assign ovf        = ovf_q;
  assign sat        = sat_q;
  assign last_beat  = (beat == BW'(BEATS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= LOAD;
    else      state <= state_n;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      LOAD:    if (fir_valid && smp_cnt == '1) state_n = COMPUTE;
      COMPUTE: if (stage == SW'(LOGN - 1) && bf_cnt == '1) state_n = OUT_R;
      OUT_R:   if (last_beat) state_n = OUT_I;
      OUT_I:   if (last_beat) state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  // Butterfly addressing: clearing the low bits of b and doubling yields the group base.
  always_comb begin
    b_ext   = {1'b0, bf_cnt};
    h       = LOGN'(N / 2) >> stage;
    j       = b_ext & (h - 1'b1);
    top     = ((b_ext & ~(h - 1'b1)) << 1) | j;
    bot     = top | h;
    tw_addr = (LOGN-1)'(j << stage);
  end

  always_comb begin
    xt_re = mem_re[top];
    xt_im = mem_im[top];
    xb_re = mem_re[bot];
    xb_im = mem_im[bot];
    d_re  = xt_re - xb_re;
    d_im  = xt_im - xb_im;
    w_re  = tw_re;
    w_im  = inv_q ? -tw_im : tw_im;
    p_rr  = (2*IW)'(d_re) * (2*IW)'(w_re);
    p_ii  = (2*IW)'(d_im) * (2*IW)'(w_im);
    p_ri  = (2*IW)'(d_re) * (2*IW)'(w_im);
    p_ir  = (2*IW)'(d_im) * (2*IW)'(w_re);
    s_re  = (p_rr - p_ii) >>> 16;
    s_im  = (p_ri + p_ir) >>> 16;
    y_re  = s_re[IW-1:0];
    y_im  = s_im[IW-1:0];
  end

  // NOTE: the frame buffer has no reset; its contents are rewritten by every LOAD before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == LOAD && fir_valid) begin
        mem_re[smp_cnt] <= IW'(signed'(fir_d)) <<< 8;
        mem_im[smp_cnt] <= '0;
      end else if (state == COMPUTE) begin
        mem_re[top] <= xt_re + xb_re;
        mem_im[top] <= xt_im + xb_im;
        mem_re[bot] <= y_re;
        mem_im[bot] <= y_im;
      end
    end
  end

  // Output lanes: bit-reversed read, optional 1/N scaling, 8.8 extraction with saturation.
  always_comb begin
    fft_d    = '0;
    lane_sat = 1'b0;
    out_addr = '0;
    v_raw    = '0;
    v        = '0;
    if (fftr_valid || ffti_valid) begin
      for (int l = 0; l < LANES; l++) begin
        out_addr = bitrev(LOGN'(int'(beat) * LANES + l));
        v_raw    = fftr_valid ? mem_re[out_addr] : mem_im[out_addr];
        v        = inv_q ? (v_raw >>> LOGN) : v_raw;
        if ((&v[IW-1:DW+7]) || !(|v[IW-1:DW+7])) begin
          fft_d[l*DW +: DW] = v[DW+7:8];
        end else begin
          lane_sat          = 1'b1;
          fft_d[l*DW +: DW] = v[IW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      smp_cnt      <= '0;
      bf_cnt       <= '0;
      stage        <= '0;
      beat         <= '0;
      frame_cnt    <= '0;
      inv_q        <= 1'b0;
      frame_done_q <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (fir_valid && !in_ready) ovf_q <= 1'b1;
      if (lane_sat) sat_q <= 1'b1;
      case (state)
        LOAD: if (fir_valid) begin
          smp_cnt <= smp_cnt + 1'b1;
          if (smp_cnt == '0) inv_q <= inverse;
        end
        COMPUTE: begin
          bf_cnt <= bf_cnt + 1'b1;
          if (bf_cnt == '1) stage <= (stage == SW'(LOGN - 1)) ? '0 : stage + 1'b1;
        end
        OUT_R: beat <= last_beat ? '0 : beat + 1'b1;
        OUT_I: begin
          beat <= last_beat ? '0 : beat + 1'b1;
          if (last_beat) begin
            frame_done_q <= 1'b1;
            if (frame_cnt != FW'(FRAMES)) frame_cnt <= frame_cnt + 1'b1;
            if (frame_cnt == FW'(FRAMES - 1)) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_iter_core.sv
// Scoreboard bench for fft_iter_core (N=16, LANES=16, FRAMES=4): directed frames with
// hand-computed spectra queued at stimulus time and checked by an independent output monitor.
`timescale 1ns/1ps
module tb_fft_iter_core;
  localparam int N = 16, DW = 16, IW = 32, LANES = 16, FRAMES = 4;
  localparam int VW = LANES * DW;

  logic            clk, rst, fir_valid, inverse;
  logic [DW-1:0]   fir_d;
  logic            in_ready, fftr_valid, ffti_valid, frame_done, done, ovf, sat;
  logic [2:0]      tw_addr;
  logic [IW-1:0]   tw_re, tw_im;
  logic [VW-1:0]   fft_d;

  fft_iter_core #(.N(N), .DW(DW), .IW(IW), .LANES(LANES), .FRAMES(FRAMES)) dut (
    .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d), .inverse(inverse),
    .in_ready(in_ready), .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
    .fftr_valid(fftr_valid), .ffti_valid(ffti_valid), .fft_d(fft_d),
    .frame_done(frame_done), .done(done), .ovf(ovf), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // W_16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16) in Q16.16.
  int tw_re_tab [8] = '{65536, 60547, 46341, 25080, 0, -25080, -46341, -60547};
  int tw_im_tab [8] = '{0, -25080, -46341, -60547, -65536, -60547, -46341, -25080};
  assign tw_re = IW'(tw_re_tab[tw_addr]);
  assign tw_im = IW'(tw_im_tab[tw_addr]);

  typedef struct {
    logic          imag;
    logic [VW-1:0] d;
    int            tol;
    string         tag;
  } exp_t;

  exp_t          exp_q [$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] samp [N];

  task automatic check(input string name, input logic ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per output beat; idle cycles must show fft_d = 0.
  initial begin
    forever begin
      @(negedge clk);
      if (fftr_valid || ffti_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected output beat", 1'b0, {fftr_valid, ffti_valid}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check({mon_e.tag, " beat kind"}, (ffti_valid == mon_e.imag) && (fftr_valid != ffti_valid),
                ffti_valid, mon_e.imag);
          for (int l = 0; l < LANES; l++) begin
            logic signed [DW-1:0] av, rv;
            int diff;
            av = fft_d[l*DW +: DW];
            rv = mon_e.d[l*DW +: DW];
            diff = int'(av) - int'(rv);
            check($sformatf("%s %s[%0d]", mon_e.tag, mon_e.imag ? "im" : "re", l),
                  (diff <= mon_e.tol) && (diff >= -mon_e.tol), av, rv);
          end
        end
      end else begin
        check("idle fft_d zero", fft_d == '0, fft_d[63:0], 0);
      end
    end
  end

  task automatic feed(input logic inv);
    for (int n = 0; n < N; n++) begin
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) check("in_ready wait", 1'b0, in_ready, 1);
      fir_valid = 1'b1;
      fir_d     = samp[n];
      inverse   = inv;
      @(posedge clk);
      #1 fir_valid = 1'b0;
    end
  endtask

  // Cycle k counts from the first cycle after the last accepted sample (T+k).
  task automatic wait_frame(output int r_at, output int i_at, output int fd_at, output logic done_fd);
    r_at = -1; i_at = -1; fd_at = -1; done_fd = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (fftr_valid && r_at < 0) r_at = k;
      if (ffti_valid && i_at < 0) i_at = k;
      if (frame_done) begin
        fd_at   = k;
        done_fd = done;
        break;
      end
    end
  endtask

  task automatic push_frame(input string tag, input logic [VW-1:0] re_v, input logic [VW-1:0] im_v,
                            input int tol);
    exp_t e;
    e.tag = tag; e.tol = tol;
    e.imag = 1'b0; e.d = re_v; exp_q.push_back(e);
    e.imag = 1'b1; e.d = im_v; exp_q.push_back(e);
  endtask

  task automatic run_frame(input string tag, input logic inv, input logic [VW-1:0] re_v,
                           input logic [VW-1:0] im_v, input int tol, output logic done_fd);
    int r_at, i_at, fd_at;
    push_frame(tag, re_v, im_v, tol);
    feed(inv);
    wait_frame(r_at, i_at, fd_at, done_fd);
    check({tag, " fftr_valid latency"}, r_at == 33, r_at, 33);
    check({tag, " ffti_valid latency"}, i_at == 34, i_at, 34);
    check({tag, " frame_done latency"}, fd_at == 35, fd_at, 35);
  endtask

  task automatic set_impulse();
    foreach (samp[i]) samp[i] = '0;
    samp[0] = 16'h0100;
  endtask

  initial begin
    automatic int cos_tab [N] = '{256, 237, 181, 98, 0, -98, -181, -237,
                                  -256, -237, -181, -98, 0, 98, 181, 237};
    logic [VW-1:0] re_v;
    logic          dfd;
    int            drops, low;

    #200_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] re_v;
    logic          dfd;
    int            drops, low;
    int            cos_tab [N];

    cos_tab = '{256, 237, 181, 98, 0, -98, -181, -237, -256, -237, -181, -98, 0, 98, 181, 237};
    rst = 1'b0; fir_valid = 1'b0; fir_d = '0; inverse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {in_ready, fftr_valid, ffti_valid, frame_done, done, ovf, sat} == 7'b1000000,
          {in_ready, fftr_valid, ffti_valid, frame_done, done, ovf, sat}, 7'b1000000);
    check("reset tw_addr", tw_addr == 3'd0, tw_addr, 0);
    rst = 1'b1;

    set_impulse();
    run_frame("impulse", 1'b0, {LANES{16'h0100}}, '0, 0, dfd);

    foreach (samp[i]) samp[i] = 16'h0100;
    re_v = '0; re_v[15:0] = 16'h1000;
    run_frame("dc", 1'b0, re_v, '0, 3, dfd);

    foreach (samp[i]) samp[i] = DW'(cos_tab[i]);
    re_v = '0; re_v[1*DW +: DW] = 16'h0800; re_v[15*DW +: DW] = 16'h0800;
    run_frame("cosine", 1'b0, re_v, '0, 3, dfd);

    set_impulse();
    run_frame("inverse", 1'b1, {LANES{16'h0010}}, '0, 0, dfd);
    check("inverse sat clear", sat == 1'b0, sat, 0);

    foreach (samp[i]) samp[i] = 16'h7FFF;
    re_v = '0; re_v[15:0] = 16'h7FFF;
    run_frame("saturation", 1'b0, re_v, '0, 0, dfd);
    check("saturation sat set", sat == 1'b1, sat, 1);

    // Backpressure: 40 cycles of continuous valid; samples 16..39 carry junk that must be dropped.
    push_frame("backpressure", {LANES{16'h0100}}, '0, 0);
    drops = 0; low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      fir_valid = 1'b1;
      inverse   = 1'b0;
      fir_d     = (i == 0) ? 16'h0100 : ((i < 16) ? 16'h0000 : 16'h1234);
      if (!in_ready) begin
        drops++;
        low++;
      end
      @(posedge clk);
    end
    #1 fir_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) break;
      low++;
    end
    check("backpressure dropped samples", drops == 24, drops, 24);
    check("backpressure in_ready low cycles", low == 34, low, 34);
    check("backpressure frame_done on return", frame_done == 1'b1, frame_done, 1);
    check("backpressure ovf", ovf == 1'b1, ovf, 1);

    // Reset mid-COMPUTE: this frame is aborted, so nothing is queued for it.
    set_impulse();
    feed(1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid-compute reset outputs", {in_ready, fftr_valid, ffti_valid, frame_done, done, ovf, sat} == 7'b1000000,
          {in_ready, fftr_valid, ffti_valid, frame_done, done, ovf, sat}, 7'b1000000);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    run_frame("post-reset impulse", 1'b0, {LANES{16'h0100}}, '0, 0, dfd);

    // Frame count from a clean reset: done must rise with the 4th frame_done and stay up.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int f = 1; f <= 4; f++) begin
      set_impulse();
      run_frame($sformatf("count frame %0d", f), 1'b0, {LANES{16'h0100}}, '0, 0, dfd);
      check($sformatf("done at frame_done %0d", f), dfd == (f == 4), dfd, (f == 4));
    end
    repeat (5) @(negedge clk);
    check("done sticky", done == 1'b1, done, 1);
    check("scoreboard drained", exp_q.size() == 0, exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_iter_core.md
Name: fft_iter_core

Overview:
Parametrised successor to the fixed 16-point FFT. It collects N serial 8.8 samples from the FIR stage into a frame buffer and runs an in-place radix-2 decimation-in-frequency (DIF) FFT, one butterfly per cycle. It then emits the natural-order spectrum LANES points per beat, all real beats first, then all imaginary beats. New relative to the fixed block: generic N and lane count, inverse mode, input backpressure, saturation and drop flags, and a frame-count `done`.

Parameters:
- N, 16: transform length; power of 2, 4..256; LOGN = log2(N).
- DW, 16: sample width (input and output); signed, FRAC = 8 fraction bits.
- IW, 32: internal word width; signed Q16.16.
- LANES, 16: output points per beat; must divide N.
- FRAMES, 64: frames processed before `done` asserts.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-low.
- fir_valid  in  1  `fir_d` valid this cycle.
- fir_d  in  DW  input sample, signed 8.8.
- inverse  in  1  sampled with the first sample of each frame; 1 selects IFFT.
- in_ready  out  1  a sample is accepted when fir_valid && in_ready.
- tw_addr  out  LOGN-1  twiddle index k into an external combinational ROM.
- tw_re, tw_im  in  IW  W_N^k = cos(2πk/N) − j·sin(2πk/N), Q16.16.
- fftr_valid  out  1  `fft_d` carries real parts.
- ffti_valid  out  1  `fft_d` carries imaginary parts.
- fft_d  out  LANES*DW  lane l occupies bits [l*DW +: DW]; signed 8.8.
- frame_done  out  1  one-cycle pulse per completed frame.
- done  out  1  sticky; set after FRAMES frames.
- ovf  out  1  sticky; a sample was offered while in_ready = 0 and was dropped.
- sat  out  1  sticky; an output value was saturated.

Behaviour:
- Reset (rst = 0 at a clock edge):
  - state goes to LOAD; sample, butterfly and frame counters go to 0.
  - in_ready = 1; all other outputs = 0; buffer contents are don't-care.
  - Reset in any state, including mid-COMPUTE or mid-output, aborts the frame.
- States: LOAD → COMPUTE → OUT_R → OUT_I → LOAD.
- LOAD:
  - in_ready = 1; each accepted sample n (0..N−1) is stored as re = sign-extended fir_d << 8, im = 0.
  - The cycle after sample N−1 is accepted, state goes to COMPUTE and in_ready drops to 0.
  - `inverse` is latched when sample 0 is accepted.
- COMPUTE: C = (N/2)·LOGN cycles, one butterfly per cycle.
  - Stage s = 0..LOGN−1, half-span h = N >> (s+1).
  - Butterfly b = 0..N/2−1: j = b mod h, top = (b / h)·2h + j, bot = top + h, tw_addr = j << s.
  - Buffer reads are combinational; writes occur at the clock edge, so there is no hazard across stage boundaries.
  - x[top] ← x[top] + x[bot]; x[bot] ← (x[top] − x[bot])·W.
  - Inverse mode uses conj(W), i.e. tw_im negated.
  - Complex multiply: four 64-bit products; each sum is arithmetically shifted right by 16, then truncated to IW.
  - Adds wrap at IW bits.
- OUT_R: N/LANES consecutive beats with fftr_valid = 1.
  - Beat t, lane l presents point n = t·LANES + l, read from buffer address bitrev(n).
- OUT_I: same sequence of beats for the imaginary part, with ffti_valid = 1.
- Output conversion:
  - In inverse mode, first arithmetic-shift the value right by LOGN (1/N scaling).
  - Take bits [DW+7:8]; if bits above DW+7 are not a sign-extension, saturate to 0x7FFF / 0x8000 and set `sat`.
- fft_d = 0 whenever neither fftr_valid nor ffti_valid is asserted.
- Frame end:
  - frame_done pulses in the cycle after the last OUT_I beat; the same cycle re-enters LOAD with in_ready = 1.
  - The frame counter increments on frame_done; `done` sets when it reaches FRAMES.
  - Processing continues after `done`.
- Latency: if the last sample is accepted at cycle T, COMPUTE spans T+1..T+C, first fftr_valid is at T+C+1, frame_done is at T+C+2N/LANES+1.
- Input during in_ready = 0: the sample is dropped, `ovf` sets, and the stored frame is unaffected.

Test Plan:
- Impulse, forward, N=16, LANES=16: x[0] = 0x0100, others 0 → all 16 real = 0x0100, all imag = 0x0000; fftr_valid at T+33, ffti_valid at T+34, frame_done at T+35.
- DC: 16 × 0x0100 → X[0] = 0x1000, X[1..15] = 0x0000 (±3 LSB), imag all ±3.
- Cosine: x[n] = round(256·cos(2πn/16)) → X[1] = X[15] = 0x0800 ±3, other bins ±3, imag ±3.
- Inverse: impulse with inverse = 1 → all real = 0x0010, imag = 0; `sat` = 0.
- Saturation: 16 × 0x7FFF, forward → X[0] real = 0x7FFF, `sat` = 1.
- Backpressure: continuous fir_valid for 40 cycles → samples 16..39 dropped (in_ready low for 34 cycles), `ovf` = 1.
- Reset mid-COMPUTE: rst = 0 at cycle T+10 → next cycle in_ready = 1, all flags and valids 0; a following clean impulse frame is correct.
- Frame count: FRAMES = 4, 4 back-to-back frames → `done` rises with the 4th frame_done and stays high.
